// File: rtl/timer_irq_periph_pkg.sv
// Shared definitions for the timer/IRQ peripheral: register offsets,
// TCON bit positions and the bus address-match helper.
package timer_irq_periph_pkg;

  // Byte offsets of the registers from the peripheral base address
  localparam logic [31:0] OFF_TH      = 32'h0000_0000;
  localparam logic [31:0] OFF_TL      = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
  localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

  // TCON bit positions: count enable, interrupt enable, interrupt status
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  // Word-aligned match: the two byte-select bits of the bus address are ignored
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] off);
    return (addr & ~32'h3) == ((base + off) & ~32'h3);
  endfunction

endpackage

// File: rtl/timer_irq_periph_counter.sv
// timer_counter: the TL counter. Counts while enabled, reloads from the
// reload value instead of wrapping to zero, and flags the overflow edge.
// A software write of TL takes priority over both increment and reload;
// the overflow flag is still raised on that edge so status is not lost.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_wr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_reload,
  output logic [31:0] o_tl,
  output logic        o_ovf
);

  logic [31:0] r_tl;
  logic        w_ovf;

  // Overflow happens on the edge where an enabled counter sits at all-ones
  assign w_ovf = i_en && (r_tl == 32'hFFFF_FFFF);

  // TL register: write > reload > increment > hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tl <= 32'd0;
    end else if (i_wr) begin
      r_tl <= i_wdata;
    end else if (w_ovf) begin
      r_tl <= i_reload;
    end else if (i_en) begin
      r_tl <= r_tl + 32'd1;
    end
  end

  assign o_tl  = r_tl;
  assign o_ovf = w_ovf;

endmodule

// File: rtl/timer_irq_periph.sv
// timer_irq_periph: memory-mapped timer on the data-memory bus. Drives the
// level IRQ line of the core. Reads are combinational, writes commit on the
// rising clock edge. Handshake: a bus access is a single cycle -- MemWrite
// with a mapped address commits at the next rising edge, MemRead returns
// data in the same cycle; there is no stall or ready signal.
// Build option: define TIMER_SYSTICK_EN to add the free-running read-only
// SYSTICK counter at BASE+0x14 (unmapped and absent otherwise).
module timer_irq_periph
  import timer_irq_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          TCON_W    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IRQ
);

  logic              w_hit_th, w_hit_tl, w_hit_tcon;
  logic              w_wr_th, w_wr_tl, w_wr_tcon;
  logic [31:0]       r_th;
  logic [TCON_W-1:0] r_tcon;
  logic [TCON_W-1:0] w_tcon_nxt;
  logic              r_irq;
  logic [31:0]       w_tl;
  logic              w_ovf;
  logic [1:0]        w_unused_addr;

  assign w_unused_addr = Addr[1:0];

  assign w_hit_th   = addr_hit(Addr, BASE_ADDR, OFF_TH);
  assign w_hit_tl   = addr_hit(Addr, BASE_ADDR, OFF_TL);
  assign w_hit_tcon = addr_hit(Addr, BASE_ADDR, OFF_TCON);

  assign w_wr_th   = MemWrite & w_hit_th;
  assign w_wr_tl   = MemWrite & w_hit_tl;
  assign w_wr_tcon = MemWrite & w_hit_tcon;

  timer_counter u_counter (
    .clk      (clk),
    .reset    (reset),
    .i_en     (r_tcon[TCON_EN]),
    .i_wr     (w_wr_tl),
    .i_wdata  (WriteData),
    .i_reload (r_th),
    .o_tl     (w_tl),
    .o_ovf    (w_ovf)
  );

  // TH reload register, software-written only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th <= 32'd0;
    end else if (w_wr_th) begin
      r_th <= WriteData;
    end
  end

  // Next TCON: software write first, then an overflow with IE set forces
  // status high so a same-edge acknowledge cannot swallow the interrupt
  always_comb begin
    w_tcon_nxt = r_tcon;
    if (w_wr_tcon) begin
      w_tcon_nxt[TCON_EN] = WriteData[TCON_EN];
      w_tcon_nxt[TCON_IE] = WriteData[TCON_IE];
      w_tcon_nxt[TCON_IS] = WriteData[TCON_IS];
    end
    if (w_ovf && r_tcon[TCON_IE]) begin
      w_tcon_nxt[TCON_IS] = 1'b1;
    end
  end

  // TCON and the IRQ flop; IRQ follows the new status on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcon <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_tcon <= w_tcon_nxt;
      r_irq  <= w_tcon_nxt[TCON_IE] & w_tcon_nxt[TCON_IS];
    end
  end

`ifdef TIMER_SYSTICK_EN
  logic [31:0] r_systick;
  logic        w_hit_systick;

  assign w_hit_systick = addr_hit(Addr, BASE_ADDR, OFF_SYSTICK);

  // Free-running tick counter, independent of TCON, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_systick <= 32'd0;
    end else begin
      r_systick <= r_systick + 32'd1;
    end
  end
`endif

  // Combinational read mux; zero when not reading or address unmapped
  always_comb begin
    ReadData = 32'd0;
    if (MemRead) begin
      if (w_hit_th) begin
        ReadData = r_th;
      end else if (w_hit_tl) begin
        ReadData = w_tl;
      end else if (w_hit_tcon) begin
        ReadData[TCON_W-1:0] = r_tcon;
      end
`ifdef TIMER_SYSTICK_EN
      else if (w_hit_systick) begin
        ReadData = r_systick;
      end
`endif
    end
  end

  assign IRQ = r_irq;

endmodule

// File: tb/tb_timer_irq_periph.sv
// Bench for timer_irq_periph: expected register values are pushed to a
// queue at each checkpoint and popped as the bus reads return data.
`timescale 1ns/1ps
module tb_timer_irq_periph;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk, reset, MemRead, MemWrite, IRQ;
  logic [31:0] Addr, WriteData, ReadData;

  logic [31:0] exp_q[$];
  logic [31:0] got, exp;
  int          n_vec, n_bad;
  string       reg_name[3] = '{"TH", "TL", "TCON"};

  timer_irq_periph #(.BASE_ADDR(BASE), .TCON_W(3)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .IRQ(IRQ)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: called at a falling edge; a write commits at the next rising edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; Addr = a; WriteData = d;
    @(negedge clk);
    MemWrite = 1'b0; Addr = 32'd0; WriteData = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    MemRead = 1'b1; Addr = a;
    #1;
    d = ReadData;
    MemRead = 1'b0; Addr = 32'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL reset_init %s: got %h want %h", reg_name[k], got, exp); end
    end
    n_vec++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL reset_init IRQ: got %b want 0", IRQ); end
    @(negedge clk); reset = 1'b1;
    bus_write(BASE + 32'h0, 32'h55);
    bus_write(BASE + 32'h4, 32'd2);
    bus_write(BASE + 32'h8, 32'd3);
    repeat (3) @(negedge clk);
    exp_q.push_back(32'h55); exp_q.push_back(32'd5); exp_q.push_back(32'd3);
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL reset_precount %s: got %h want %h", reg_name[k], got, exp); end
    end
    #1 reset = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL reset_async %s: got %h want %h", reg_name[k], got, exp); end
    end
    n_vec++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL reset_async IRQ: got %b want 0", IRQ); end
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL reset_release %s: got %h want %h", reg_name[k], got, exp); end
    end
    n_vec++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL reset_release IRQ: got %b want 0", IRQ); end
  endtask

  task automatic test_reload_irq();
    bus_write(BASE + 32'h0, 32'hFFFF_FFFD);
    bus_write(BASE + 32'h4, 32'hFFFF_FFFE);
    bus_write(BASE + 32'h8, 32'd3);
    @(negedge clk);
    exp_q.push_back(32'hFFFF_FFFD); exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'd3);
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL reload_pre %s: got %h want %h", reg_name[k], got, exp); end
    end
    n_vec++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL reload_pre IRQ: got %b want 0", IRQ); end
    @(negedge clk);
    exp_q.push_back(32'hFFFF_FFFD); exp_q.push_back(32'hFFFF_FFFD); exp_q.push_back(32'd7);
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL reload_ovf %s: got %h want %h", reg_name[k], got, exp); end
    end
    n_vec++; if (IRQ !== 1'b1) begin n_bad++; $display("FAIL reload_ovf IRQ: got %b want 1", IRQ); end
  endtask

  task automatic test_ack();
    bus_write(BASE + 32'h8, 32'd3);
    exp_q.push_back(32'hFFFF_FFFD); exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'd3);
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL ack %s: got %h want %h", reg_name[k], got, exp); end
    end
    n_vec++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL ack IRQ: got %b want 0", IRQ); end
    @(negedge clk);
    exp_q.push_back(32'hFFFF_FFFF);
    bus_read(BASE + 32'h4, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_bad++; $display("FAIL ack_count TL: got %h want %h", got, exp); end
  endtask

  task automatic test_collision();
    // This write lands on the overflow edge with IE set
    bus_write(BASE + 32'h8, 32'd3);
    exp_q.push_back(32'hFFFF_FFFD); exp_q.push_back(32'hFFFF_FFFD); exp_q.push_back(32'd7);
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL collision %s: got %h want %h", reg_name[k], got, exp); end
    end
    n_vec++; if (IRQ !== 1'b1) begin n_bad++; $display("FAIL collision IRQ: got %b want 1", IRQ); end
    @(negedge clk);
    n_vec++; if (IRQ !== 1'b1) begin n_bad++; $display("FAIL collision_hold IRQ: got %b want 1", IRQ); end
  endtask

  task automatic test_ie_clear();
    // TL is FFFFFFFE here; clearing IE keeps status, drops IRQ
    bus_write(BASE + 32'h8, 32'd5);
    exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'd5);
    for (int k = 1; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL ie_clear %s: got %h want %h", reg_name[k], got, exp); end
    end
    n_vec++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL ie_clear IRQ: got %b want 0", IRQ); end
    @(negedge clk);
    exp_q.push_back(32'hFFFF_FFFD); exp_q.push_back(32'd5);
    for (int k = 1; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL ie_clear_ovf %s: got %h want %h", reg_name[k], got, exp); end
    end
    n_vec++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL ie_clear_ovf IRQ: got %b want 0", IRQ); end
  endtask

  task automatic test_irq_disabled();
    bus_write(BASE + 32'h8, 32'd0);
    bus_write(BASE + 32'h0, 32'h100);
    bus_write(BASE + 32'h8, 32'd1);
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h100); exp_q.push_back(32'h100); exp_q.push_back(32'd1);
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL noirq_ovf %s: got %h want %h", reg_name[k], got, exp); end
    end
    n_vec++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL noirq_ovf IRQ: got %b want 0", IRQ); end
    bus_write(BASE + 32'h8, 32'd3);
    repeat (4) @(negedge clk);
    exp_q.push_back(32'h100); exp_q.push_back(32'h105); exp_q.push_back(32'd3);
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL noirq_ie %s: got %h want %h", reg_name[k], got, exp); end
    end
    n_vec++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL noirq_ie IRQ: got %b want 0", IRQ); end
  endtask

  task automatic test_freeze_tl_write();
    bus_write(BASE + 32'h8, 32'd0);
    repeat (3) @(negedge clk);
    exp_q.push_back(32'h106);
    bus_read(BASE + 32'h4, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_bad++; $display("FAIL freeze TL: got %h want %h", got, exp); end
    // TL write on the overflow edge: data wins, status still set
    bus_write(BASE + 32'h4, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h8, 32'd3);
    bus_write(BASE + 32'h4, 32'h1234);
    exp_q.push_back(32'h100); exp_q.push_back(32'h1234); exp_q.push_back(32'd7);
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL tlwr_ovf %s: got %h want %h", reg_name[k], got, exp); end
    end
    n_vec++; if (IRQ !== 1'b1) begin n_bad++; $display("FAIL tlwr_ovf IRQ: got %b want 1", IRQ); end
    bus_write(BASE + 32'h8, 32'd0);
  endtask

  task automatic test_bus_decode();
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h10, 32'hFFFF_FFFF);
    bus_write(32'h1000_0004, 32'hFFFF_FFFF);
    exp_q.push_back(32'h100); exp_q.push_back(32'h1235); exp_q.push_back(32'd0);
    for (int k = 0; k < 3; k++) begin
      bus_read(BASE + 32'(4 * k), got); exp = exp_q.pop_front(); n_vec++;
      if (got !== exp) begin n_bad++; $display("FAIL decode %s: got %h want %h", reg_name[k], got, exp); end
    end
    n_vec++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL decode IRQ: got %b want 0", IRQ); end
    MemRead = 1'b0; Addr = BASE + 32'h4; #1; got = ReadData; Addr = 32'd0;
    exp_q.push_back(32'd0); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_bad++; $display("FAIL decode_noread: got %h want %h", got, exp); end
    exp_q.push_back(32'd0);
    bus_read(BASE + 32'hC, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_bad++; $display("FAIL decode_unmapped: got %h want %h", got, exp); end
    exp_q.push_back(32'h1235);
    bus_read(BASE + 32'h5, got); exp = exp_q.pop_front(); n_vec++;
    if (got !== exp) begin n_bad++; $display("FAIL decode_bytebits: got %h want %h", got, exp); end
  endtask

  task automatic test_systick();
    logic [31:0] t0, t1;
`ifdef TIMER_SYSTICK_EN
    @(negedge clk);
    bus_read(BASE + 32'h14, t0);
    repeat (10) @(negedge clk);
    bus_read(BASE + 32'h14, t1);
    exp_q.push_back(32'd10); exp = exp_q.pop_front(); n_vec++;
    if ((t1 - t0) !== exp) begin n_bad++; $display("FAIL systick_delta: got %h want %h", t1 - t0, exp); end
`else
    t0 = 32'd0;
    bus_read(BASE + 32'h14, t1);
    exp_q.push_back(t0); exp = exp_q.pop_front(); n_vec++;
    if (t1 !== exp) begin n_bad++; $display("FAIL systick_unmapped: got %h want %h", t1, exp); end
`endif
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    MemRead = 1'b0; MemWrite = 1'b0; Addr = 32'd0; WriteData = 32'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    test_reset();
    test_reload_irq();
    test_ack();
    test_collision();
    test_ie_clear();
    test_irq_disabled();
    test_freeze_tl_write();
    test_bus_decode();
    test_systick();
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
